// File: rtl/coin_return_dispenser_pkg.sv
// Shared constants and types for the coin return dispenser.
// No logic: denominations, widths, inventory limits and FSM encoding.
// Not applicable: holds no flow control.
package coin_return_dispenser_pkg;

  // Number of denominations; index 0 is the smallest coin.
  localparam int K_NUM_COINS  = 3;
  // Width of every money amount.
  localparam int K_TOTAL_BITS = 31;
  // Width of each per-denomination inventory counter.
  localparam int CNT_BITS     = 8;

  typedef logic [K_TOTAL_BITS-1:0] amount_t;
  typedef logic [CNT_BITS-1:0]     count_t;
  typedef logic [K_NUM_COINS-1:0]  coin_vec_t;
  typedef logic [K_NUM_COINS*CNT_BITS-1:0] count_bus_t;

  // Denomination values, smallest first.
  localparam amount_t COIN_VAL0 = 31'd100;
  localparam amount_t COIN_VAL1 = 31'd500;
  localparam amount_t COIN_VAL2 = 31'd1000;

  // Inventory after reset, and the ceiling deposits cannot push past.
  localparam count_t INIT_COUNT = 8'd8;
  localparam count_t CNT_MAX    = 8'd255;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPENSE = 1'b1
  } state_t;

  // Value of denomination idx; idx above the largest maps to the largest.
  function automatic amount_t coin_val(input int idx);
    amount_t v;
    case (idx)
      0:       v = COIN_VAL0;
      1:       v = COIN_VAL1;
      default: v = COIN_VAL2;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest denomination that fits the remainder and is in stock.
// Latency: purely combinational, zero cycles.
// No flow control; the caller decides whether to act on the choice.
module coin_select
  import coin_return_dispenser_pkg::*;
(
  input  logic [K_TOTAL_BITS-1:0]          remainder,
  input  logic [K_NUM_COINS*CNT_BITS-1:0]  counts,
  output logic [K_NUM_COINS-1:0]           choice,
  output logic [K_TOTAL_BITS-1:0]          value,
  output logic                             none
);

  // Scan upward so a larger qualifying denomination overrides a smaller one.
  always_comb begin
    choice = '0;
    value  = '0;
    none   = 1'b1;
    for (int i = 0; i < K_NUM_COINS; i++) begin
      if ((coin_val(i) <= remainder) &&
          (counts[i*CNT_BITS +: CNT_BITS] != '0)) begin
        choice    = '0;
        choice[i] = 1'b1;
        value     = coin_val(i);
        none      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/coin_return_dispenser.sv
// Change dispenser: ejects a refund one coin per clock, largest first, from a tracked inventory.
// Latency: n-coin return shows coin k after edge k and o_done after edge n+1 (n+2 cycles start-to-done).
// No backpressure: i_start is taken only in IDLE; requests while busy are dropped, never queued.
module coin_return_dispenser
  import coin_return_dispenser_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_start,
  input  logic [K_TOTAL_BITS-1:0]          i_return_amount,
  input  logic [K_NUM_COINS-1:0]           i_coin_in,
  output logic [K_NUM_COINS-1:0]           o_return_coin,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_short,
  output logic [K_TOTAL_BITS-1:0]          o_remainder,
  output logic [K_NUM_COINS*CNT_BITS-1:0]  o_coin_count
);

  state_t     state;
  state_t     state_nxt;
  amount_t    remainder;
  amount_t    remainder_nxt;
  count_bus_t counts;

  coin_vec_t  sel_choice;
  amount_t    sel_value;
  logic       sel_none;

  // Coins actually leaving the machine this cycle.
  coin_vec_t  take;

  coin_vec_t  return_coin_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic       short_nxt;
  amount_t    rem_out_nxt;

  coin_select u_coin_select (
    .remainder (remainder),
    .counts    (counts),
    .choice    (sel_choice),
    .value     (sel_value),
    .none      (sel_none)
  );

  assign take         = ((state == ST_DISPENSE) && !sel_none) ? sel_choice : '0;
  assign o_coin_count = counts;

  // State, remainder and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      remainder     <= '0;
      o_return_coin <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_short       <= 1'b0;
      o_remainder   <= '0;
    end else begin
      state         <= state_nxt;
      remainder     <= remainder_nxt;
      o_return_coin <= return_coin_nxt;
      o_busy        <= busy_nxt;
      o_done        <= done_nxt;
      o_short       <= short_nxt;
      o_remainder   <= rem_out_nxt;
    end
  end

  // Next-state and next-output decode; short/remainder hold until the next completion.
  always_comb begin
    state_nxt       = state;
    remainder_nxt   = remainder;
    return_coin_nxt = '0;
    busy_nxt        = o_busy;
    done_nxt        = 1'b0;
    short_nxt       = o_short;
    rem_out_nxt     = o_remainder;
    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (i_start) begin
          state_nxt     = ST_DISPENSE;
          remainder_nxt = i_return_amount;
          busy_nxt      = 1'b1;
        end
      end
      ST_DISPENSE: begin
        if (!sel_none) begin
          return_coin_nxt = sel_choice;
          remainder_nxt   = remainder - sel_value;
        end else begin
          // Nothing more can be paid: report whatever is still owed.
          state_nxt   = ST_IDLE;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
          short_nxt   = (remainder != '0);
          rem_out_nxt = remainder;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Inventory: deposits add (saturating), ejected coins subtract; both at once cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < K_NUM_COINS; i++) begin
        counts[i*CNT_BITS +: CNT_BITS] <= INIT_COUNT;
      end
    end else begin
      for (int i = 0; i < K_NUM_COINS; i++) begin
        if (i_coin_in[i] && !take[i]) begin
          if (counts[i*CNT_BITS +: CNT_BITS] != CNT_MAX) begin
            counts[i*CNT_BITS +: CNT_BITS] <= counts[i*CNT_BITS +: CNT_BITS] + 8'd1;
          end
        end else if (take[i] && !i_coin_in[i]) begin
          counts[i*CNT_BITS +: CNT_BITS] <= counts[i*CNT_BITS +: CNT_BITS] - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for coin_return_dispenser: directed returns against a cycle model plus literal expectations.
// Latency of each return is measured from the accepting edge.
// Inputs change #1 after the rising edge; outputs are compared on the falling edge.
module tb_coin_return_dispenser;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [30:0] i_return_amount;
  logic [2:0]  i_coin_in;
  logic [2:0]  o_return_coin;
  logic        o_busy;
  logic        o_done;
  logic        o_short;
  logic [30:0] o_remainder;
  logic [23:0] o_coin_count;

  coin_return_dispenser dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .i_return_amount (i_return_amount),
    .i_coin_in       (i_coin_in),
    .o_return_coin   (o_return_coin),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_short         (o_short),
    .o_remainder     (o_remainder),
    .o_coin_count    (o_coin_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         val[3] = '{100, 500, 1000};
  int         m_inv[3];
  bit         m_busy;
  int         m_rem;
  logic [2:0] m_coin;
  bit         m_done;
  bit         m_short;
  int         m_remain;
  bit         model_live = 1'b0;
  int         m_pick;
  int         m_delta;

  always @(posedge clk) begin
    model_live = 1'b1;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_inv[i] = 8;
      m_busy = 0; m_rem = 0; m_coin = '0; m_done = 0; m_short = 0; m_remain = 0;
    end else begin
      // Largest coin that fits what is still owed and is in stock.
      m_pick = -1;
      if (m_busy)
        for (int i = 2; i >= 0; i--)
          if (m_pick < 0 && val[i] <= m_rem && m_inv[i] > 0) m_pick = i;
      for (int i = 0; i < 3; i++) begin
        m_delta = int'(i_coin_in[i]) - ((m_pick == i) ? 1 : 0);
        if (m_delta > 0 && m_inv[i] < 255) m_inv[i]++;
        else if (m_delta < 0) m_inv[i]--;
      end
      m_done = 0;
      m_coin = '0;
      if (!m_busy) begin
        if (i_start) begin
          m_busy = 1;
          m_rem  = int'(i_return_amount);
        end
      end else if (m_pick >= 0) begin
        m_coin = 3'(1 << m_pick);
        m_rem  = m_rem - val[m_pick];
      end else begin
        m_done   = 1;
        m_short  = (m_rem != 0);
        m_remain = m_rem;
        m_busy   = 0;
      end
    end
  end

  int done_seen = 0;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_live) begin
      check("coin", {29'd0, o_return_coin}, {29'd0, m_coin});
      check("busy", {31'd0, o_busy}, {31'd0, m_busy});
      check("done", {31'd0, o_done}, {31'd0, m_done});
      check("counts", {8'd0, o_coin_count},
            {8'd0, 8'(m_inv[2]), 8'(m_inv[1]), 8'(m_inv[0])});
      if (m_done) begin
        check("short", {31'd0, o_short}, {31'd0, m_short});
        check("remainder", {1'b0, o_remainder}, m_remain);
      end
      if (o_done) done_seen++;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] seq_word;
  logic        got_short;
  logic [30:0] got_rem;
  int          lat;
  int          done_before;

  // Issue one return and record coins (4 bits per coin, first coin most significant).
  task automatic run_return(input int amount);
    seq_word  = '0;
    lat       = -1;
    got_short = 1'b0;
    got_rem   = '0;
    i_start         = 1'b1;
    i_return_amount = 31'(amount);
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (o_return_coin != 3'b000) seq_word = (seq_word << 4) | {29'd0, o_return_coin};
      if (o_done) begin
        lat       = k;
        got_short = o_short;
        got_rem   = o_remainder;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: return of %0d never completed, got no done expected done", amount);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; i_start = 1'b0; i_return_amount = '0; i_coin_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_coin", {29'd0, o_return_coin}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_counts", {8'd0, o_coin_count}, 32'h080808);
    reset = 1'b0;

    // 1600 from full stock: 1000, 500, 100.
    run_return(1600);
    check("t1600_seq", seq_word, 32'h421);
    check("t1600_lat", lat, 4);
    check("t1600_short", {31'd0, got_short}, 32'd0);
    check("t1600_counts", {8'd0, o_coin_count}, 32'h070707);

    // Back to full stock, then drain 1000s down to one.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    run_return(7000);
    check("t7000_seq", seq_word, 32'h4444444);
    check("t7000_lat", lat, 8);
    check("t7000_counts", {8'd0, o_coin_count}, 32'h010808);

    // 2000 with a single 1000 left: 1000, 500, 500.
    run_return(2000);
    check("t2000_seq", seq_word, 32'h422);
    check("t2000_short", {31'd0, got_short}, 32'd0);
    check("t2000_counts", {8'd0, o_coin_count}, 32'h000608);

    // 250: two 100s, 50 left unpaid.
    run_return(250);
    check("t250_seq", seq_word, 32'h11);
    check("t250_lat", lat, 3);
    check("t250_short", {31'd0, got_short}, 32'd1);
    check("t250_rem", {1'b0, got_rem}, 32'd50);

    // Zero amount: done right after E1, no coins.
    run_return(0);
    check("t0_seq", seq_word, 32'h0);
    check("t0_lat", lat, 1);
    check("t0_short", {31'd0, got_short}, 32'd0);

    // 600 with i_start held while busy and a 100 deposited as a 100 leaves.
    i_start = 1'b1; i_return_amount = 31'd600;
    @(posedge clk); #1;                       // E0
    i_return_amount = 31'd1600;
    @(posedge clk); #1;                       // E1
    check("t600_c1", {29'd0, o_return_coin}, 32'd2);
    i_coin_in = 3'b001;
    @(posedge clk); #1;                       // E2
    check("t600_c2", {29'd0, o_return_coin}, 32'd1);
    i_coin_in = 3'b000;
    i_start   = 1'b0;
    @(posedge clk); #1;                       // E3
    check("t600_done", {31'd0, o_done}, 32'd1);
    check("t600_counts", {8'd0, o_coin_count}, 32'h000506);
    @(posedge clk); #1;
    check("t600_idle", {31'd0, o_busy}, 32'd0);

    // Reset after E2 of a 1600 return abandons it silently.
    i_start = 1'b1; i_return_amount = 31'd1600;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    done_before = done_seen;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_coin", {29'd0, o_return_coin}, 32'd0);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    check("mid_rst_counts", {8'd0, o_coin_count}, 32'h080808);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_nodone", done_seen, done_before);

    // Deposits saturate at 255.
    i_coin_in = 3'b100;
    repeat (250) @(posedge clk);
    #1;
    check("sat_count2", {24'd0, o_coin_count[23:16]}, 32'd255);
    i_coin_in = 3'b000;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
